tile_loader: RTL and testbench

TILE_LOADER -- requirements
Module: tile_loader

---
 rtl/tile_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_tile_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_loader.sv
// tile_loader
// Fills a 32x32 tile RAM (16-bit pixels, row-major) either by reading the
// tile from a framebuffer over an Avalon-MM pipelined read master, or by
// filling it with a constant colour.
//
// Ports
//   clk, resetn              clock (rising edge), async active-low reset
//   start, clear             one-cycle requests (clear wins if both)
//   addr_in, stride_in       byte address of pixel (0,0) and row pitch
//   clear_color              fill value for a clear
//   busy, done               operation in progress / one-cycle end pulse
//   ram_wr_addr/_data/wren   tile RAM write port
//   master_*                 Avalon-MM pipelined read master
module tile_loader (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        clear,
    input  logic [31:0] addr_in,
    input  logic [15:0] stride_in,
    input  logic [15:0] clear_color,
    output logic        busy,
    output logic        done,
    output logic [9:0]  ram_wr_addr,
    output logic [15:0] ram_wr_data,
    output logic        ram_wren,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_read_data,
    input  logic        master_read_data_valid,
    input  logic        master_wait_request
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CLEAR  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [9:0] NUM_READS = 10'd512;
    localparam logic [4:0] CREDITS   = 5'd8;

    state_t        state_r, state_s;
    logic          busy_r, done_r, ram_wren_r, master_read_r;
    logic [9:0]    ram_wr_addr_r;
    logic [15:0]   ram_wr_data_r;
    logic [31:0]   master_address_r;
    logic [31:0]   base_r;
    logic [3:0]    col_r;
    logic [13:0]   stride_r;
    logic [15:0]   color_r;
    logic [9:0]    rd_cnt_r;
    logic [10:0]   wr_cnt_r;
    logic          half_r;
    logic [3:0]    outst_r, fifo_cnt_r;
    logic [2:0]    wp_r, rp_r;
    logic [31:0]   fifo_mem_r [8];

    logic          start_ok_s, clear_ok_s, rd_acc_s, push_s, wr_go_s, pop_s;
    logic          credit_ok_s, more_rd_s;
    logic [3:0]    outst_nx_s, fifo_nx_s, col_nx_s;
    logic [9:0]    rd_cnt_nx_s;
    logic [31:0]   base_nx_s, addr_al_s, head_s;
    logic          unused_bits_s;

    assign unused_bits_s = ^{addr_in[1:0], stride_in[1:0]};

    assign start_ok_s  = (state_r == S_IDLE) && start && !clear;
    assign clear_ok_s  = (state_r == S_IDLE) && clear;
    assign addr_al_s   = {addr_in[31:2], 2'b00};
    assign rd_acc_s    = master_read_r && !master_wait_request;
    // Responses with nothing outstanding are stray and dropped here.
    assign push_s      = master_read_data_valid && (outst_r != 4'd0);
    assign wr_go_s     = (state_r == S_LOAD) && (fifo_cnt_r != 4'd0) && !wr_cnt_r[10];
    assign pop_s       = wr_go_s && half_r;
    assign head_s      = fifo_mem_r[rp_r];
    assign outst_nx_s  = outst_r + {3'd0, rd_acc_s} - {3'd0, push_s};
    assign fifo_nx_s   = fifo_cnt_r + {3'd0, push_s} - {3'd0, pop_s};
    assign rd_cnt_nx_s = rd_cnt_r + {9'd0, rd_acc_s};
    assign more_rd_s   = rd_cnt_nx_s < NUM_READS;
    // A raised master_read already holds one credit, so a new read is only
    // raised while in-flight reads plus buffered words leave room for it.
    assign credit_ok_s = ({1'b0, outst_nx_s} + {1'b0, fifo_nx_s}) < CREDITS;
    // col wraps 15 -> 0 on its own; the row base steps by the pitch then.
    assign col_nx_s    = col_r + 4'd1;
    assign base_nx_s   = (col_r == 4'd15) ? (base_r + {16'd0, stride_r, 2'b00}) : base_r;

    assign busy           = busy_r;
    assign done           = done_r;
    assign ram_wr_addr    = ram_wr_addr_r;
    assign ram_wr_data    = ram_wr_data_r;
    assign ram_wren       = ram_wren_r;
    assign master_address = master_address_r;
    assign master_read    = master_read_r;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an operation ends once the write to 1023 is on the port.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (clear) begin
                    state_s = S_CLEAR;
                end else if (start) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD, S_CLEAR: begin
                if (wr_cnt_r[10]) begin
                    state_s = S_FINISH;
                end else begin
                    state_s = state_r;
                end
            end
            S_FINISH: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Return FIFO storage and pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_r <= 3'd0;
            rp_r <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                fifo_mem_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wp_r] <= master_read_data;
                wp_r <= wp_r + 3'd1;
            end
            if (pop_s) begin
                rp_r <= rp_r + 3'd1;
            end
        end
    end

    // Datapath: read issue, credit tracking and tile RAM writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            ram_wren_r       <= 1'b0;
            ram_wr_addr_r    <= 10'd0;
            ram_wr_data_r    <= 16'd0;
            master_read_r    <= 1'b0;
            master_address_r <= 32'd0;
            base_r           <= 32'd0;
            col_r            <= 4'd0;
            stride_r         <= 14'd0;
            color_r          <= 16'd0;
            rd_cnt_r         <= 10'd0;
            wr_cnt_r         <= 11'd0;
            half_r           <= 1'b0;
            outst_r          <= 4'd0;
            fifo_cnt_r       <= 4'd0;
        end else begin
            busy_r     <= (state_s == S_LOAD) || (state_s == S_CLEAR);
            done_r     <= (state_s == S_FINISH);
            outst_r    <= outst_nx_s;
            fifo_cnt_r <= fifo_nx_s;
            case (state_r)
                S_IDLE: begin
                    ram_wren_r <= 1'b0;
                    if (start_ok_s || clear_ok_s) begin
                        base_r           <= addr_al_s;
                        col_r            <= 4'd0;
                        stride_r         <= stride_in[15:2];
                        color_r          <= clear_color;
                        rd_cnt_r         <= 10'd0;
                        wr_cnt_r         <= 11'd0;
                        half_r           <= 1'b0;
                        master_address_r <= addr_al_s;
                        master_read_r    <= start_ok_s;
                    end else begin
                        master_read_r <= 1'b0;
                    end
                end
                S_LOAD: begin
                    rd_cnt_r <= rd_cnt_nx_s;
                    if (rd_acc_s) begin
                        base_r           <= base_nx_s;
                        col_r            <= col_nx_s;
                        master_address_r <= base_nx_s + {26'd0, col_nx_s, 2'b00};
                    end
                    // Hold a stalled request; otherwise issue while reads and credit remain.
                    master_read_r <= (master_read_r && master_wait_request) ||
                                     (more_rd_s && credit_ok_s);
                    if (wr_go_s) begin
                        ram_wren_r    <= 1'b1;
                        ram_wr_addr_r <= wr_cnt_r[9:0];
                        ram_wr_data_r <= half_r ? head_s[31:16] : head_s[15:0];
                        wr_cnt_r      <= wr_cnt_r + 11'd1;
                        half_r        <= !half_r;
                    end else begin
                        ram_wren_r <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    master_read_r <= 1'b0;
                    if (!wr_cnt_r[10]) begin
                        ram_wren_r    <= 1'b1;
                        ram_wr_addr_r <= wr_cnt_r[9:0];
                        ram_wr_data_r <= color_r;
                        wr_cnt_r      <= wr_cnt_r + 11'd1;
                    end else begin
                        ram_wren_r <= 1'b0;
                    end
                end
                S_FINISH: begin
                    ram_wren_r    <= 1'b0;
                    master_read_r <= 1'b0;
                end
                default: begin
                    ram_wren_r    <= 1'b0;
                    master_read_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_loader.sv
// Scoreboard bench for tile_loader: a bus memory model returns each word's
// own address, expected RAM writes are queued when a read is accepted and
// popped as the DUT writes them.
module tb_tile_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] addr_in = 32'd0;
    logic [15:0] stride_in = 16'd0;
    logic [15:0] clear_color = 16'd0;
    logic        busy, done, ram_wren, master_read;
    logic [9:0]  ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic [31:0] master_address;
    logic [31:0] master_read_data = 32'd0;
    logic        master_read_data_valid = 1'b0;
    logic        master_wait_request = 1'b0;

    always #5 clk = ~clk;

    tile_loader dut (
        .clk(clk), .resetn(resetn), .start(start), .clear(clear),
        .addr_in(addr_in), .stride_in(stride_in), .clear_color(clear_color),
        .busy(busy), .done(done), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_wren(ram_wren),
        .master_address(master_address), .master_read(master_read),
        .master_read_data(master_read_data),
        .master_read_data_valid(master_read_data_valid),
        .master_wait_request(master_wait_request)
    );

    typedef struct { logic [9:0] a; logic [15:0] d; } wr_t;
    typedef struct { logic [31:0] d; int due; } rsp_t;

    wr_t         sbq[$];
    rsp_t        rspq[$];
    int          nchk = 0, nerr = 0;
    int          cyc = 0, nrd = 0, nwr = 0, ndone = 0, last_wr_cyc = -10;
    int          lat = 1, stall_left = 0, rand_stall = 0, max_outst = 0;
    bit          hold_rsp = 1'b0, stalled_prev = 1'b0;
    logic [31:0] stall_addr = 32'd0, exp_base = 32'd0, exp_stride = 32'd0;
    int          exp_col = 0, exp_wr = 0;
    logic [15:0] ram [1024];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus memory model, write scoreboard and protocol monitor.
    initial begin : mem_model
        wr_t w;
        rsp_t r;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            cyc++;
            if (ram_wren) begin
                nwr++;
                ram[ram_wr_addr] = ram_wr_data;
                if (sbq.size() == 0) begin
                    check_val("unexpected_write", {22'd0, ram_wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    w = sbq.pop_front();
                    check_val("wr_addr", {22'd0, ram_wr_addr}, {22'd0, w.a});
                    check_val("wr_data", {16'd0, ram_wr_data}, {16'd0, w.d});
                end
                last_wr_cyc = cyc;
            end
            if (done) begin
                ndone++;
                check_val("done_gap", cyc - last_wr_cyc, 1);
                check_val("busy_at_done", {31'd0, busy}, 0);
            end
            if (stalled_prev) begin
                check_val("stall_read_held", {31'd0, master_read}, 1);
                check_val("stall_addr_held", master_address, stall_addr);
            end
            master_read_data_valid = 1'b0;
            master_read_data = $urandom;
            if (!hold_rsp && rspq.size() > 0 && rspq[0].due <= cyc) begin
                r = rspq.pop_front();
                master_read_data_valid = 1'b1;
                master_read_data = r.d;
            end
            if (master_read && (stall_left > 0 ||
                (rand_stall != 0 && $urandom_range(3, 0) == 0))) begin
                master_wait_request = 1'b1;
                if (stall_left > 0) stall_left--;
            end else begin
                master_wait_request = 1'b0;
            end
            stalled_prev = master_read && master_wait_request;
            stall_addr = master_address;
            if (master_read && !master_wait_request) begin
                ea = exp_base + 32'(4 * exp_col);
                check_val("rd_addr", master_address, ea);
                r.d = master_address;
                r.due = cyc + lat;
                rspq.push_back(r);
                w.a = 10'(exp_wr);
                w.d = ea[15:0];
                sbq.push_back(w);
                w.a = 10'(exp_wr + 1);
                w.d = ea[31:16];
                sbq.push_back(w);
                exp_wr += 2;
                nrd++;
                if (rspq.size() > max_outst) max_outst = rspq.size();
                exp_col++;
                if (exp_col == 16) begin
                    exp_col = 0;
                    exp_base = exp_base + exp_stride;
                end
            end
        end
    end

    task automatic pulse(input bit s, input bit c);
        @(posedge clk); #1 start = s; clear = c;
        @(posedge clk); #1 start = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = ndone;
        n = 0;
        while (ndone == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_val("op_completed", ndone - d0, 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_idle(input string tag);
        #1;
        check_val({tag, "_busy"}, {31'd0, busy}, 0);
        check_val({tag, "_read"}, {31'd0, master_read}, 0);
        check_val({tag, "_wren"}, {31'd0, ram_wren}, 0);
        check_val({tag, "_done"}, {31'd0, done}, 0);
    endtask

    task automatic run_load(input logic [31:0] a, input logic [15:0] st, input int l,
                            input int stall, input int rnd, input bit poke);
        int r0, w0, d0;
        r0 = nrd; w0 = nwr; d0 = ndone;
        addr_in = a;
        stride_in = st;
        exp_base = {a[31:2], 2'b00};
        exp_stride = {16'd0, st[15:2], 2'b00};
        exp_col = 0;
        exp_wr = 0;
        max_outst = 0;
        lat = l;
        stall_left = stall;
        rand_stall = rnd;
        pulse(1'b1, 1'b0);
        check_val("busy_after_start", {31'd0, busy}, 1);
        addr_in = 32'hDEAD_BEE0;
        stride_in = 16'h1234;
        if (poke) begin
            repeat (30) @(posedge clk);
            pulse(1'b1, 1'b0);
        end
        wait_done(6000);
        check_val("load_reads", nrd - r0, 512);
        check_val("load_writes", nwr - w0, 1024);
        check_val("load_dones", ndone - d0, 1);
        check_val("load_sb_empty", sbq.size(), 0);
        check_val("max_outst_le8", {31'd0, max_outst <= 8}, 1);
        check_idle("after_load");
    endtask

    initial begin : main
        int r0, w0, d0, c0, n;
        wr_t w;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 0);
        check_val("rst_done", {31'd0, done}, 0);
        check_val("rst_wren", {31'd0, ram_wren}, 0);
        check_val("rst_read", {31'd0, master_read}, 0);
        check_val("rst_wr_addr", {22'd0, ram_wr_addr}, 0);
        check_val("rst_wr_data", {16'd0, ram_wr_data}, 0);
        check_val("rst_maddr", master_address, 0);
        resetn = 1'b1;

        run_load(32'h0000_1000, 16'd2048, 1, 0, 0, 1'b0);
        check_val("ram0", {16'd0, ram[0]}, 32'h1000);
        check_val("ram1", {16'd0, ram[1]}, 32'h0000);
        check_val("ram32", {16'd0, ram[32]}, 32'h1800);
        check_val("ram1022", {16'd0, ram[1022]}, 32'h083C);
        check_val("ram1023", {16'd0, ram[1023]}, 32'h0001);

        run_load(32'h0000_1000, 16'd2048, 1, 5, 0, 1'b0);
        run_load(32'h0000_1000, 16'd2048, 20, 0, 0, 1'b1);
        check_val("lat20_ram32", {16'd0, ram[32]}, 32'h1800);
        run_load(32'hFFFF_FF03, 16'h0042, 3, 0, 1, 1'b0);

        // Clear requested together with start: clear only.
        r0 = nrd; w0 = nwr; d0 = ndone;
        clear_color = 16'hF800;
        addr_in = 32'h0000_4000;
        stride_in = 16'd64;
        for (int i = 0; i < 1024; i++) begin
            w.a = 10'(i);
            w.d = 16'hF800;
            sbq.push_back(w);
        end
        pulse(1'b1, 1'b1);
        clear_color = 16'h001F;
        n = 0;
        while (nwr == w0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        c0 = last_wr_cyc;
        wait_done(3000);
        check_val("clear_writes", nwr - w0, 1024);
        check_val("clear_span", last_wr_cyc - c0, 1023);
        check_val("clear_reads", nrd - r0, 0);
        check_val("clear_dones", ndone - d0, 1);
        check_val("clear_ram1023", {16'd0, ram[1023]}, 32'hF800);
        check_idle("after_clear");

        // Reset in the middle of a load, then late responses.
        r0 = nrd;
        addr_in = 32'h0004_0000;
        stride_in = 16'h0400;
        exp_base = 32'h0004_0000;
        exp_stride = 32'h0000_0400;
        exp_col = 0;
        exp_wr = 0;
        lat = 20;
        stall_left = 0;
        rand_stall = 0;
        pulse(1'b1, 1'b0);
        n = 0;
        while (nrd - r0 < 100 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check_val("reached_100_reads", nrd - r0, 100);
        #1 resetn = 1'b0;
        hold_rsp = 1'b1;
        #1;
        check_val("mid_rst_busy", {31'd0, busy}, 0);
        check_val("mid_rst_read", {31'd0, master_read}, 0);
        check_val("mid_rst_wren", {31'd0, ram_wren}, 0);
        check_val("mid_rst_maddr", master_address, 0);
        check_val("mid_rst_wr_addr", {22'd0, ram_wr_addr}, 0);
        check_val("mid_rst_wr_data", {16'd0, ram_wr_data}, 0);
        sbq.delete();
        while (rspq.size() > 3) void'(rspq.pop_back());
        w0 = nwr; d0 = ndone;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        hold_rsp = 1'b0;
        repeat (12) @(posedge clk);
        check_val("late_rsp_writes", nwr - w0, 0);
        check_val("late_rsp_dones", ndone - d0, 0);
        check_idle("after_reset");

        run_load(32'h0000_1000, 16'd2048, 1, 0, 0, 1'b0);
        check_val("post_rst_ram0", {16'd0, ram[0]}, 32'h1000);
        check_val("post_rst_ram32", {16'd0, ram[32]}, 32'h1800);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
